fft_digit_reverse_buffer: RTL and testbench

Output reorder stage that sits directly after the radix-4 SDF FFT pipeline. It accepts the FFT's digit-reversed output stream using the same valid-qualified streaming interface. It emits each N-point frame in natural frequency order, one sample per clock. A two-bank ping-pong memory lets frame k+1 be written while frame k is read, so a continuous input stream produces a continuous output stream.

---
 rtl/fft_digit_reverse_buffer.sv | 199 +++++++++++++++++++
 tb/tb_fft_digit_reverse_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_digit_reverse_buffer.sv
// fft_digit_reverse_buffer
// Output reorder stage for a radix-4 SDF FFT. Each N-point frame arrives in
// base-4 digit-reversed order and is written into one bank of a ping-pong
// RAM at its natural address. The other bank is read out sequentially, so
// a continuous input stream produces a continuous natural-order output.
//
// Optional feature macro: DRB_FRAME_MARKERS_EN
//   Adds output_first, output_last (frame boundary strobes) and a sticky
//   overflow flag. When the macro is undefined, those ports do not exist
//   and overflowing samples are dropped silently.
module fft_digit_reverse_buffer #(
  parameter int WIDTH = 32,
  parameter int N     = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_en,
  input  logic [WIDTH-1:0] input_real,
  input  logic [WIDTH-1:0] input_imag,
  output logic             output_en,
  output logic [WIDTH-1:0] output_real,
  output logic [WIDTH-1:0] output_imag
`ifdef DRB_FRAME_MARKERS_EN
  ,
  output logic             output_first,
  output logic             output_last,
  output logic             overflow
`endif
);

  localparam int ADDR_W = $clog2(N);
  localparam int DIGITS = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  // N has to be a power of 4 so the address splits into whole base-4 digits.
  generate
    if (N < 4 || (1 << ADDR_W) != N || (ADDR_W % 2) != 0) begin : g_bad_n
      $error("fft_digit_reverse_buffer: N must be a power of 4");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Write side state
  logic [ADDR_W-1:0] wcnt;
  logic              wbank;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_blocked;
  logic              wr_accept;
  logic              frame_done;

  // Bank occupancy flags
  logic [1:0] bank_full;
  logic [1:0] full_set;
  logic [1:0] full_clr;
  logic [1:0] full_next;

  // Read side state
  state_t            state;
  state_t            state_next;
  logic              rbank;
  logic              rbank_next;
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] rcnt_next;
  logic              rd_en;
  logic              read_done;

  // Ping-pong storage: the bank select is the top address bit.
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  // Base-4 digit reversal of the write counter: digit gi moves to the
  // mirrored position, giving the natural-order address of this sample.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_rev4
      assign wr_addr[2*gi +: 2] = wcnt[2*(DIGITS-1-gi) +: 2];
    end
  endgenerate

  // Bank flag bookkeeping: independent set and clear terms per bank. A bank
  // whose last word is being read on this edge counts as free, so the writer
  // can start the next frame on the very edge the reader lets go of it.
  always_comb begin
    read_done  = (state == READ) && (rcnt == LAST_IDX);
    full_clr   = 2'b00;
    if (read_done) begin
      full_clr[rbank] = 1'b1;
    end
    wr_blocked = bank_full[wbank] & ~full_clr[wbank];
    wr_accept  = input_en & ~wr_blocked;
    frame_done = wr_accept && (wcnt == LAST_IDX);
    full_set   = 2'b00;
    if (frame_done) begin
      full_set[wbank] = 1'b1;
    end
    full_next  = (bank_full & ~full_clr) | full_set;
  end

  // Write pointer, write bank and bank flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt      <= '0;
      wbank     <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= full_next;
      if (wr_accept) begin
        wcnt <= wcnt + 1'b1;
        if (frame_done) begin
          wbank <= ~wbank;
        end
      end
    end
  end

  // RAM write port; contents are intentionally never cleared.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[{wbank, wr_addr}] <= {input_real, input_imag};
    end
  end

  // Read FSM next-state: sweep a full bank, chaining straight into the
  // other bank when it is already waiting so there is no output bubble.
  always_comb begin
    state_next = state;
    rbank_next = rbank;
    rcnt_next  = rcnt;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rbank]) begin
          state_next = READ;
          rcnt_next  = '0;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rcnt == LAST_IDX) begin
          rbank_next = ~rbank;
          rcnt_next  = '0;
          if (!bank_full[~rbank]) begin
            state_next = IDLE;
          end
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rbank <= 1'b0;
      rcnt  <= '0;
    end else begin
      state <= state_next;
      rbank <= rbank_next;
      rcnt  <= rcnt_next;
    end
  end

  // Synchronous RAM read into the output register; data holds when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      output_en   <= 1'b0;
      output_real <= '0;
      output_imag <= '0;
    end else begin
      output_en <= rd_en;
      if (rd_en) begin
        {output_real, output_imag} <= mem[{rbank, rcnt}];
      end
    end
  end

`ifdef DRB_FRAME_MARKERS_EN
  // Frame boundary strobes aligned with output_en, plus sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      output_first <= 1'b0;
      output_last  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      output_first <= rd_en && (rcnt == '0);
      output_last  <= rd_en && (rcnt == LAST_IDX);
      overflow     <= overflow | (input_en & wr_blocked);
    end
  end
`endif

endmodule

// File: tb/tb_fft_digit_reverse_buffer.sv
// Testbench for fft_digit_reverse_buffer: an N=16 and an N=64 instance,
// scoreboard queues filled when a frame's last sample is driven and drained
// by per-instance monitors on the falling clock edge.
module tb_fft_digit_reverse_buffer;
  localparam int W = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic         en16, oen16;
  logic [W-1:0] re16, im16, ore16, oim16;
  logic         en64, oen64;
  logic [W-1:0] re64, im64, ore64, oim64;
`ifdef DRB_FRAME_MARKERS_EN
  logic first16, last16, ovf16, first64, last64, ovf64;
`endif

  fft_digit_reverse_buffer #(.WIDTH(W), .N(16)) dut16 (
    .clock(clock), .reset(reset),
    .input_en(en16), .input_real(re16), .input_imag(im16),
    .output_en(oen16), .output_real(ore16), .output_imag(oim16)
`ifdef DRB_FRAME_MARKERS_EN
    , .output_first(first16), .output_last(last16), .overflow(ovf16)
`endif
  );

  fft_digit_reverse_buffer #(.WIDTH(W), .N(64)) dut64 (
    .clock(clock), .reset(reset),
    .input_en(en64), .input_real(re64), .input_imag(im64),
    .output_en(oen64), .output_real(ore64), .output_imag(oim64)
`ifdef DRB_FRAME_MARKERS_EN
    , .output_first(first64), .output_last(last64), .overflow(ovf64)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] q16[$];
  logic [2*W-1:0] q64[$];
  logic [2*W-1:0] hold16 = '0, hold64 = '0, e16, e64;
  int run16 = 0, maxrun16 = 0, pos16 = 0, pos64 = 0;
  int cnt16 = 0, cnt64 = 0;
  logic [2*W-1:0] fr16[16];
  logic [2*W-1:0] fr64[64];

  // Vector table for N=16: natural output index -> stream index it carries.
  typedef struct {
    int natural_idx;
    int stream_idx;
  } vec_t;
  vec_t tbl[16];

  // Base-4 digit reversal computed arithmetically.
  function automatic int digrev(input int k, input int ndig);
    int r = 0;
    int v = k;
    for (int d = 0; d < ndig; d++) begin
      r = r * 4 + (v % 4);
      v = v / 4;
    end
    return r;
  endfunction

  // Monitor for the N=16 instance.
  always @(negedge clock) begin
    if (reset) begin
      if (oen16) begin
        run16++;
        if (run16 > maxrun16) maxrun16 = run16;
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL extra16: got re=%0d im=%0d, want no output", ore16, oim16);
        end else begin
          e16 = q16.pop_front();
          hold16 = e16;
          if ({ore16, oim16} !== e16)  begin
            errors++;
            $display("FAIL data16: got re=%0d im=%0d, want re=%0d im=%0d",
                     ore16, oim16, e16[2*W-1:W], e16[W-1:0]);
          end else
            $display("out16 pos=%0d re=%0d im=%0d ok", pos16, ore16, oim16);
        end
`ifdef DRB_FRAME_MARKERS_EN
        checks++;
        if (first16 !== (pos16 == 0) || last16 !== (pos16 == 15)) begin
          errors++;
          $display("FAIL marker16: pos=%0d first=%0b last=%0b", pos16, first16, last16);
        end
`endif
        pos16 = (pos16 + 1) % 16;
      end else begin
        run16 = 0;
        checks++;
        if ({ore16, oim16} !== hold16) begin
          errors++;
          $display("FAIL hold16: got %h, want %h", {ore16, oim16}, hold16);
        end
      end
    end
  end

  // Monitor for the N=64 instance.
  always @(negedge clock) begin
    if (reset) begin
      if (oen64) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL extra64: got re=%0d im=%0d, want no output", ore64, oim64);
        end else begin
          e64 = q64.pop_front();
          hold64 = e64;
          if ({ore64, oim64} !== e64) begin
            errors++;
            $display("FAIL data64: got re=%0d im=%0d, want re=%0d im=%0d",
                     ore64, oim64, e64[2*W-1:W], e64[W-1:0]);
          end else
            $display("out64 pos=%0d re=%0d im=%0d ok", pos64, ore64, oim64);
        end
`ifdef DRB_FRAME_MARKERS_EN
        checks++;
        if (first64 !== (pos64 == 0) || last64 !== (pos64 == 63)) begin
          errors++;
          $display("FAIL marker64: pos=%0d first=%0b last=%0b", pos64, first64, last64);
        end
`endif
        pos64 = (pos64 + 1) % 64;
      end else begin
        checks++;
        if ({ore64, oim64} !== hold64) begin
          errors++;
          $display("FAIL hold64: got %h, want %h", {ore64, oim64}, hold64);
        end
      end
    end
  end

  // Drive one cycle on the N=16 instance; queue the frame when it completes.
  task automatic drive16(input logic en, input int re, input int im);
    en16 = en;
    re16 = W'(re);
    im16 = W'(im);
    @(posedge clock);
    #1;
    if (en) begin
      fr16[cnt16] = {W'(re), W'(im)};
      cnt16++;
      if (cnt16 == 16) begin
        for (int a = 0; a < 16; a++) q16.push_back(fr16[tbl[a].stream_idx]);
        cnt16 = 0;
      end
    end
  endtask

  task automatic drive64(input logic en, input int re, input int im);
    en64 = en;
    re64 = W'(re);
    im64 = W'(im);
    @(posedge clock);
    #1;
    if (en) begin
      fr64[cnt64] = {W'(re), W'(im)};
      cnt64++;
      if (cnt64 == 64) begin
        for (int a = 0; a < 64; a++) q64.push_back(fr64[digrev(a, 3)]);
        cnt64 = 0;
      end
    end
  endtask

  // Called just after the edge that accepted a frame's last sample:
  // output_en must be high from 2 to last_c edges later and low otherwise.
  task automatic check_window(input string name, input int last_c);
    logic want;
    for (int c = 0; c <= last_c + 2; c++) begin
      if (c > 0) @(posedge clock);
      @(negedge clock);
      want = (c >= 2 && c <= last_c);
      checks++;
      if (oen16 !== want) begin
        errors++;
        $display("FAIL %s: edge+%0d output_en=%0b, want %0b", name, c, oen16, want);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else
      $display("check %s = %0d ok", name, got);
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clock);
    checks++;
    if (oen16 !== 1'b0 || ore16 !== '0 || oim16 !== '0 ||
        oen64 !== 1'b0 || ore64 !== '0 || oim64 !== '0) begin
      errors++;
      $display("FAIL %s: en16=%0b re16=%0d im16=%0d en64=%0b re64=%0d im64=%0d, want all 0",
               name, oen16, ore16, oim16, oen64, ore64, oim64);
    end else
      $display("check %s ok", name);
  endtask

  initial begin
    int nat16[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    for (int i = 0; i < 16; i++) begin
      tbl[i].natural_idx = i;
      tbl[i].stream_idx  = nat16[i];
    end

    reset = 1'b0;
    en16 = 1'b0; re16 = '0; im16 = '0;
    en64 = 1'b0; re64 = '0; im64 = '0;
    repeat (2) check_reset_state("reset_state");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single frame: values 0..15, imag 100+k.
    maxrun16 = 0;
    for (int k = 0; k < 16; k++) drive16(1'b1, k, 100 + k);
    en16 = 1'b0;
    check_window("latency_single", 17);
    check_int("run_single", maxrun16, 16);

    // Three back-to-back frames: output must be one unbroken 48-cycle run.
    maxrun16 = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 16; k++) drive16(1'b1, 16 * f + k, 100 + 16 * f + k);
    en16 = 1'b0;
    repeat (25) @(posedge clock);
    #1;
    check_int("run_b2b", maxrun16, 48);

    // Input valid toggling every cycle.
    maxrun16 = 0;
    for (int k = 0; k < 16; k++) begin
      drive16(1'b1, 200 + k, 300 + k);
      if (k != 15) drive16(1'b0, 0, 0);
    end
    en16 = 1'b0;
    check_window("latency_gappy", 17);
    check_int("run_gappy", maxrun16, 16);

    // Reset at sample 9 of a frame: the partial frame must vanish.
    for (int k = 0; k < 9; k++) drive16(1'b1, 500 + k, 600 + k);
    en16 = 1'b0;
    reset = 1'b0;
    cnt16 = 0; hold16 = '0; pos16 = 0; run16 = 0;
    pos64 = 0; hold64 = '0;
    repeat (3) check_reset_state("reset_midframe");
    @(posedge clock);
    #1;
    reset = 1'b1;
    maxrun16 = 0;
    for (int k = 0; k < 16; k++) drive16(1'b1, 700 + k, 800 + k);
    en16 = 1'b0;
    check_window("latency_after_reset", 17);
    check_int("run_after_reset", maxrun16, 16);

    // N=64 frame: natural index a carries rev4(a).
    for (int k = 0; k < 64; k++) drive64(1'b1, k, 1000 + k);
    en64 = 1'b0;
    repeat (70) @(posedge clock);
    #1;

    check_int("q16_drained", q16.size(), 0);
    check_int("q64_drained", q64.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
